// File: rtl/ps2_key_sequencer.sv
// PS/2 byte stream to Q/W/E/R key events with prefix tracking, held-key bitmap and show-ahead FIFO.
// Optional macro PS2_BREAK_EVENTS_EN: also queue release events for keys that were held.
module ps2_key_sequencer #(
   parameter int unsigned DEPTH_LOG2     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                  inclock,
   input  logic                  resetn,
   input  logic [7:0]            ps2_key_data,
   input  logic                  ps2_key_pressed,
   input  logic                  key_ack,
   input  logic                  clr_overflow,
   output logic                  key_valid,
   output logic [7:0]            key_code,
   output logic                  key_is_break,
   output logic [3:0]            key_held,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow,
   output logic [1:0]            seq_state
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BRK     = 2'd1,
      S_EXT     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      tmo_cnt;
   logic [7:0]            code_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         count;

   logic       hit_c;
   logic [1:0] idx_c;
   logic [7:0] ascii_c;
   logic       make_c, brk_c, push_c, pop_c, full_c, wr_en_c, drop_c;

   // Scancode to key index / ASCII lookup
   always_comb begin
      hit_c   = 1'b1;
      idx_c   = 2'd0;
      ascii_c = 8'h00;
      case (ps2_key_data)
         8'h15:   begin idx_c = 2'd0; ascii_c = 8'h51; end
         8'h1D:   begin idx_c = 2'd1; ascii_c = 8'h57; end
         8'h24:   begin idx_c = 2'd2; ascii_c = 8'h45; end
         8'h2D:   begin idx_c = 2'd3; ascii_c = 8'h52; end
         default: hit_c = 1'b0;
      endcase
   end

   assign make_c = ps2_key_pressed && (state == S_IDLE) && hit_c
                   && (ps2_key_data != 8'hF0) && (ps2_key_data != 8'hE0);
   assign brk_c  = ps2_key_pressed && (state == S_BRK) && hit_c;

`ifdef PS2_BREAK_EVENTS_EN
   assign push_c = (make_c && !key_held[idx_c]) || (brk_c && key_held[idx_c]);
`else
   assign push_c = make_c && !key_held[idx_c];
`endif

   assign pop_c   = key_ack && key_valid;
   assign full_c  = (count == CW'(DEPTH));
   assign wr_en_c = push_c && (!full_c || pop_c);
   assign drop_c  = push_c && full_c && !pop_c;

   // Prefix state machine, idle timeout and held-key bitmap
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         tmo_cnt  <= '0;
         key_held <= '0;
      end else begin
         if (ps2_key_pressed) begin
            tmo_cnt <= '0;
            case (state)
               S_IDLE: begin
                  if (ps2_key_data == 8'hF0)      state <= S_BRK;
                  else if (ps2_key_data == 8'hE0) state <= S_EXT;
               end
               S_BRK:     state <= S_IDLE;
               S_EXT:     state <= (ps2_key_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
               S_EXT_BRK: state <= S_IDLE;
            endcase
         end else if (state != S_IDLE) begin
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state   <= S_IDLE;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
         if (make_c) key_held[idx_c] <= 1'b1;
         if (brk_c)  key_held[idx_c] <= 1'b0;
      end
   end

`ifdef PS2_BREAK_EVENTS_EN
   logic brk_mem [DEPTH];

   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) brk_mem[i] <= 1'b0;
      end else if (wr_en_c) begin
         brk_mem[wr_ptr] <= brk_c;
      end
   end

   assign key_is_break = brk_mem[rd_ptr];
`else
   assign key_is_break = 1'b0;
`endif

   // Event FIFO; a push into a full FIFO is accepted when the head pops in the same cycle
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) code_mem[i] <= 8'h00;
      end else begin
         if (wr_en_c) begin
            code_mem[wr_ptr] <= ascii_c;
            wr_ptr           <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop_c) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         if (wr_en_c && !pop_c)      count <= count + CW'(1);
         else if (!wr_en_c && pop_c) count <= count - CW'(1);
         if (drop_c)            overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   assign key_valid  = (count != '0);
   assign key_code   = code_mem[rd_ptr];
   assign fifo_count = count;
   assign seq_state  = state;

endmodule
